uart_word_collector: RTL

Consumes the byte stream of the UART receiver (one-cycle `rx_ready` strobe with `rx_data`, sticky `rx_ferr`) and packs every four consecutive bytes little-endian into a 32-bit word. Completed words are buffered in a first-word-fall-through FIFO read by the CPU loader over a valid/ready handshake. Receive errors, FIFO overflow and stalled partial words are detected and reported.

---
 rtl/uart_pkg.sv | 9 +
 rtl/sync_fifo_fwft.sv | 48 ++++
 rtl/uart_word_collector.sv | 93 +++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and the collector's word type.
// No logic; imported by the receiver side and the word collector.
package uart_pkg;
    localparam int WORD_BYTES       = 4;
    localparam int WORD_W           = 32;
    localparam int CLK_PER_HALF_BIT = 5208;

    typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO; pop_data is the head entry.
// Latency: a push is visible at the head the cycle after the write edge.
// Backpressure: push is ignored when full unless a pop happens in the same cycle.
module sync_fifo_fwft #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    // Extra pointer bit separates full (wrapped) from empty (equal).
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count    = wr_ptr - rd_ptr;
    assign pop_data = mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/uart_word_collector.sv
// Packs UART bytes little-endian into 32-bit words and buffers them in a FWFT FIFO.
// Latency: 4th byte strobe in cycle T gives word_valid/word_data in cycle T+1.
// Backpressure: none toward the receiver; a word finished while the FIFO is full is dropped and flagged.
module uart_word_collector
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int TIMEOUT_CLK = 104160
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        rx_ready,
    input  logic [7:0]                  rx_data,
    input  logic                        rx_ferr,
    output logic                        word_valid,
    output word_t                       word_data,
    input  logic                        word_ready,
    output logic [$clog2(FIFO_DEPTH):0] word_count,
    output logic                        overflow,
    output logic                        err,
    output logic                        partial_drop
);
    localparam logic [1:0]  LAST_BYTE  = 2'(WORD_BYTES - 1);
    localparam logic [31:0] TIMEOUT_M1 = 32'(TIMEOUT_CLK - 1);

    logic [1:0]  byte_cnt;
    logic [23:0] hold;
    logic [31:0] idle_cnt;
    logic        accept;
    logic        word_done;
    logic        pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic        timeout_hit;
    word_t       new_word;

    // A byte coinciding with the framing error is already untrusted.
    assign accept      = rx_ready && !err && !rx_ferr;
    assign word_done   = accept && (byte_cnt == LAST_BYTE);
    assign new_word    = {rx_data, hold};
    assign pop         = word_valid && word_ready;
    assign word_valid  = !fifo_empty;
    assign timeout_hit = (TIMEOUT_CLK != 0) && !err && !accept
                         && (byte_cnt != 2'd0) && (idle_cnt == TIMEOUT_M1);

    always_ff @(posedge clock) begin
        if (reset) begin
            byte_cnt <= 2'd0;
        end else if (err) begin
            byte_cnt <= 2'd0;
        end else if (accept) begin
            byte_cnt <= word_done ? 2'd0 : byte_cnt + 2'd1;
        end else if (timeout_hit) begin
            byte_cnt <= 2'd0;
        end
    end

    always_ff @(posedge clock) begin
        if (accept && !word_done) hold[{byte_cnt, 3'b000} +: 8] <= rx_data;
    end

    always_ff @(posedge clock) begin
        if (reset || accept || byte_cnt == 2'd0) idle_cnt <= '0;
        else                                     idle_cnt <= idle_cnt + 32'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            err          <= 1'b0;
            overflow     <= 1'b0;
            partial_drop <= 1'b0;
        end else begin
            if (rx_ferr) err <= 1'b1;
            if (word_done && fifo_full && !pop) overflow <= 1'b1;
            partial_drop <= timeout_hit;
        end
    end

    sync_fifo_fwft #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (word_done),
        .push_data (new_word),
        .pop       (pop),
        .pop_data  (word_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (word_count)
    );
endmodule
